// File: rtl/scic_pkg.sv
// Shared opcodes, FSM encoding and decode flags for the SCIC accumulator CPU.
// No logic; widths here are the defaults the control unit and datapath agree on.
package scic_pkg;

  localparam int PC_W_DFLT   = 5;
  localparam int OPND_W_DFLT = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SHL = 4'h2;
  localparam logic [3:0] OP_SHR = 4'h3;
  localparam logic [3:0] OP_LI  = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_BR  = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_EXEC   = 3'd4
  } state_e;

  typedef struct packed {
    logic needs_rd;
    logic needs_wr;
    logic is_imm;
    logic is_br;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/scic_decoder.sv
// Opcode classifier shared by the sequencer and the ALU select logic.
// Purely combinational, zero latency; no flow control.
module scic_decoder
  import scic_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR, OP_AND: dec.needs_rd = 1'b1;
      OP_LI:   dec.is_imm   = 1'b1;
      OP_ST:   dec.needs_wr = 1'b1;
      OP_BR:   dec.is_br    = 1'b1;
      OP_NOP:  dec          = '0;
      default: dec.illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/scic_control_unit.sv
// Fetch/decode/execute sequencer owning PC and IR; 2-4 cycles per instruction plus memory waits.
// Memory requests hold until mem_ready; enable only gates the start of a new fetch.
module scic_control_unit
  import scic_pkg::*;
#(
  parameter int PC_W   = PC_W_DFLT,
  parameter int OPND_W = OPND_W_DFLT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic              rom_cs,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [31:0]       rom_data,
  output logic [OPND_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              mdr_load,
  output logic [3:0]        ac_op,
  output logic              ac_we,
  output logic [OPND_W-1:0] imm,
  output logic [PC_W-1:0]   pc,
  output logic              illegal_op,
  output logic [2:0]        state
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  dec_t              dec;

  scic_decoder u_decoder (
    .opcode (ir_q[31:28]),
    .dec    (dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (enable) begin
          ir_d    = rom_data;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.needs_rd) begin
          state_d = ST_MEM_RD;
        end else if (dec.needs_wr) begin
          state_d = ST_MEM_WR;
        end else if (dec.is_imm) begin
          state_d = ST_EXEC;
        end else begin
          // BR, NOP and illegal opcodes all return straight to FETCH
          state_d = ST_FETCH;
          if (dec.is_br) pc_d = ir_q[PC_W-1:0];
        end
      end
      ST_MEM_RD: if (mem_ready) state_d = ST_EXEC;
      ST_MEM_WR: if (mem_ready) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // rom_cs is qualified by reset_n because the state register already reads FETCH during reset
  assign rom_cs     = reset_n & enable & (state_q == ST_FETCH);
  assign rom_addr   = pc_q;
  assign pc         = pc_q;
  assign mem_addr   = ir_q[OPND_W-1:0];
  assign imm        = ir_q[OPND_W-1:0];
  assign mem_rd     = (state_q == ST_MEM_RD);
  assign mem_wr     = (state_q == ST_MEM_WR);
  assign mdr_load   = mem_rd & mem_ready;
  assign ac_we      = (state_q == ST_EXEC);
  assign ac_op      = ir_q[31:28];
  assign illegal_op = (state_q == ST_DECODE) & dec.illegal;
  assign state      = state_q;

endmodule

// File: tb/tb_scic_control_unit.sv
// Scoreboard bench: an instruction-level program walk predicts the event stream the sequencer must produce.
module tb_scic_control_unit;
  import scic_pkg::*;

  localparam int PC_W   = 5;
  localparam int OPND_W = 16;
  localparam int N_INSN = 300;

  localparam int EV_FETCH = 0;
  localparam int EV_ILL   = 1;
  localparam int EV_RD    = 2;
  localparam int EV_WR    = 3;
  localparam int EV_ACWE  = 4;

  typedef struct packed {
    int kind;
    int val;
    int op;
    int opnd;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              rom_cs;
  logic [PC_W-1:0]   rom_addr;
  logic [31:0]       rom_data;
  logic [OPND_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ready;
  logic              mdr_load;
  logic [3:0]        ac_op;
  logic              ac_we;
  logic [OPND_W-1:0] imm;
  logic [PC_W-1:0]   pc;
  logic              illegal_op;
  logic [2:0]        state;

  logic [31:0] rom [32];
  ev_t         exp_q [$];
  int          checks = 0;
  int          errors = 0;
  bit          sb_on  = 1'b0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  scic_control_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_ready  (mem_ready),
    .mdr_load   (mdr_load),
    .ac_op      (ac_op),
    .ac_we      (ac_we),
    .imm        (imm),
    .pc         (pc),
    .illegal_op (illegal_op),
    .state      (state)
  );

  task automatic chk(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Cycles per instruction with zero-wait memory
  function automatic int base_cpi(input int op);
    if (op == 4 || op == 7) return 3;
    if (op == 1 || op == 2 || op == 3 || op == 5 || op == 6 || op == 9) return 4;
    return 2;
  endfunction

  function automatic ev_t mk_ev(input int kind, input int val, input int op, input int opnd);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.op   = op;
    e.opnd = opnd;
    return e;
  endfunction

  // Walk the program one instruction at a time and list the observable events in order
  task automatic build_model();
    int mpc;
    int op;
    int opnd;
    logic [31:0] w;
    mpc = 0;
    for (int k = 0; k < N_INSN; k++) begin
      w    = rom[mpc];
      op   = int'(w[31:28]);
      opnd = int'(w[15:0]);
      exp_q.push_back(mk_ev(EV_FETCH, mpc, op, opnd));
      mpc = (mpc + 1) % 32;
      if (op == 1 || op == 2 || op == 3 || op == 5 || op == 6 || op == 9) begin
        exp_q.push_back(mk_ev(EV_RD, opnd, op, opnd));
        exp_q.push_back(mk_ev(EV_ACWE, op, op, opnd));
      end else if (op == 4) begin
        exp_q.push_back(mk_ev(EV_ACWE, op, op, opnd));
      end else if (op == 7) begin
        exp_q.push_back(mk_ev(EV_WR, opnd, op, opnd));
      end else if (op == 8) begin
        mpc = opnd % 32;
      end else if (op >= 10) begin
        exp_q.push_back(mk_ev(EV_ILL, 0, op, opnd));
      end
    end
  endtask

  task automatic sb_pop(input string name, input int kind, input int val, output bit ok, output ev_t e);
    ok = 1'b0;
    e  = '0;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checks++;
    if (e.kind != kind || e.val != val) begin
      errors++;
      $display("FAIL %s: got event kind=%0d val=%0h, expected kind=%0d val=%0h", name, kind, val, e.kind, e.val);
    end else begin
      ok = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_cs"}, rom_cs, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mdr_load"}, mdr_load, 0);
    chk({tag, "_ac_we"}, ac_we, 0);
    chk({tag, "_illegal_op"}, illegal_op, 0);
    chk({tag, "_ac_op"}, ac_op, 0);
    chk({tag, "_imm"}, imm, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_state"}, state, ST_FETCH);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every DUT event
  initial begin
    int  cyc = 0;
    int  ins_start = 0;
    int  waits = 0;
    int  cur_op = 0;
    int  cur_opnd = 0;
    int  rd_cyc = -10;
    bit  in_ins = 1'b0;
    bit  ok;
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!(sb_on && reset_n)) begin
        in_ins = 1'b0;
        continue;
      end
      if (mem_rd && mem_wr) chk("rd_wr_exclusive", 1, 0);
      if (mem_rd || mdr_load) chk("mdr_load", mdr_load, mem_rd & mem_ready);
      if (in_ins && state == ST_FETCH) begin
        chk("cycles_per_insn", cyc - ins_start, base_cpi(cur_op) + waits);
        in_ins = 1'b0;
      end
      if (in_ins && (mem_rd || mem_wr)) begin
        chk("mem_addr_held", mem_addr, cur_opnd);
        if (!mem_ready) waits++;
      end
      if (rom_cs) begin
        chk("rom_addr_eq_pc", rom_addr, pc);
        sb_pop("fetch", EV_FETCH, int'(rom_addr), ok, e);
        if (ok) begin
          in_ins    = 1'b1;
          ins_start = cyc;
          waits     = 0;
          cur_op    = e.op;
          cur_opnd  = e.opnd;
        end
      end
      if (illegal_op) sb_pop("illegal", EV_ILL, 0, ok, e);
      if (mem_rd && mem_ready) begin
        sb_pop("mem_read", EV_RD, int'(mem_addr), ok, e);
        rd_cyc = cyc;
      end
      if (mem_wr && mem_ready) sb_pop("mem_write", EV_WR, int'(mem_addr), ok, e);
      if (ac_we) begin
        sb_pop("ac_write", EV_ACWE, int'(ac_op), ok, e);
        if (ok && e.op == 4) begin
          chk("li_imm", imm, e.opnd);
          chk("li_ac_we_timing", cyc, ins_start + 2);
        end else if (ok) begin
          chk("mem_ac_we_timing", cyc, rd_cyc + 1);
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [PC_W-1:0]   pc_snap;
    logic [OPND_W-1:0] imm_snap;
    bit found;

    reset_n   = 1'b0;
    enable    = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      rom[i] = w;
    end
    rom[0]  = 32'h4000_000F;
    rom[1]  = 32'h7000_005F;
    rom[2]  = 32'h4000_0001;
    rom[3]  = 32'h1000_005F;
    rom[4]  = 32'hC000_0000;
    rom[5]  = 32'h8000_FFE7;
    rom[30] = 32'h0000_0000;
    rom[31] = 32'h0000_0000;
    build_model();

    #12;
    check_reset_outputs("por");

    // Random enable and memory wait states against the program-walk model
    sb_on = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 30000 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      enable    = ($urandom_range(0, 9) != 0);
      mem_ready = ($urandom_range(0, 9) < 6);
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    // Enable low in FETCH freezes pc, IR and state
    enable    = 1'b0;
    mem_ready = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (state == ST_FETCH) found = 1'b1;
    end
    sb_on = 1'b0;
    chk("reach_fetch_idle", found, 1);
    pc_snap  = pc;
    imm_snap = imm;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("freeze_pc", pc, pc_snap);
      chk("freeze_ir", imm, imm_snap);
      chk("freeze_state", state, ST_FETCH);
      chk("freeze_rom_cs", rom_cs, 0);
    end

    // Reset while a store waits on memory
    @(posedge clk); #1;
    reset_n   = 1'b0;
    rom[0]    = 32'h7000_0ABC;
    mem_ready = 1'b0;
    enable    = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_wr) found = 1'b1;
    end
    chk("reach_mem_wr", found, 1);
    @(negedge clk);
    chk("st_wait_mem_wr", mem_wr, 1);
    chk("st_wait_addr", mem_addr, 16'h0ABC);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_op_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("refetch_rom_cs", rom_cs, 1);
    chk("refetch_addr", rom_addr, 0);
    @(negedge clk);
    chk("refetch_state", state, ST_DECODE);
    chk("refetch_ir", imm, 16'h0ABC);
    chk("refetch_pc", pc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
